ram_arbiter: RTL and testbench

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arbiter.sv | 127 ++++++++++++
 tb/tb_ram_arbiter.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of a single-port-per-side synchronous RAM.
// Port 0 (CPU) has fixed priority. Port 1 (video scanner) is promoted after
// waiting MAX_WAIT cycles. Read data returns two edges after the transfer,
// tagged with the port that issued it.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_din_q, ram_din_d;
    // Stage 1: address is in the RAM input register. Stage 2: data is on ram_dout.
    logic                  s1_valid_q, s1_valid_d;
    logic                  s1_port_q, s1_port_d;
    logic                  s2_valid_q, s2_valid_d;
    logic                  s2_port_q, s2_port_d;

    logic                  promote;
    logic                  xfer0;
    logic                  xfer1;

    // Grant decision: port 0 first unless port 1 has aged past MAX_WAIT.
    // Promotion takes port 0's slot for that cycle regardless of req1, so a
    // promoted cycle is always exactly one lost cycle for port 0.
    always_comb begin
        promote = (MAX_WAIT != 0) && (wait_cnt_q >= WAIT_LIMIT);
        gnt0    = 1'b0;
        gnt1    = 1'b0;
        if (!rst) begin
            gnt0 = req0 && !promote;
            gnt1 = req1 && (promote || !req0);
        end
        xfer0 = req0 && gnt0;
        xfer1 = req1 && gnt1;
    end

    // Next-state for the RAM command register, read tag pipeline and aging counter.
    always_comb begin
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;
        s1_valid_d = 1'b0;
        s1_port_d  = 1'b0;
        if (xfer0) begin
            ram_we_d   = we0;
            ram_addr_d = addr0;
            ram_din_d  = wdata0;
            s1_valid_d = !we0;
            s1_port_d  = 1'b0;
        end else if (xfer1) begin
            ram_we_d   = we1;
            ram_addr_d = addr1;
            ram_din_d  = wdata1;
            s1_valid_d = !we1;
            s1_port_d  = 1'b1;
        end

        s2_valid_d = s1_valid_q;
        s2_port_d  = s1_port_q;

        if (!req1 || gnt1) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != 8'hFF) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // State registers; reset also drops any read still in the pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q <= 8'd0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_port_q  <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_port_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            s1_valid_q <= s1_valid_d;
            s1_port_q  <= s1_port_d;
            s2_valid_q <= s2_valid_d;
            s2_port_q  <= s2_port_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_waddr = ram_addr_q;
    assign ram_raddr = ram_addr_q;
    assign ram_din   = ram_din_q;
    assign rdata     = ram_dout;
    assign rvalid0   = s2_valid_q && !s2_port_q;
    assign rvalid1   = s2_valid_q && s2_port_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a MAX_WAIT=4 instance with a behavioural RAM, plus a
// MAX_WAIT=0 instance on the same inputs to observe starvation and saturation.
module tb_ram_arbiter;

    localparam int AW = 9;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, ram_we;
    logic [DW-1:0] rdata, ram_din, ram_dout;
    logic [AW-1:0] ram_waddr, ram_raddr;

    logic          n_gnt0, n_gnt1, n_rvalid0, n_rvalid1, n_ram_we;
    logic [DW-1:0] n_rdata, n_ram_din;
    logic [DW-1:0] n_ram_dout = '0;
    logic [AW-1:0] n_ram_waddr, n_ram_raddr;

    logic          pl_en;
    logic [AW-1:0] pl_addr;
    logic [DW-1:0] pl_data;

    always #5 clk = ~clk;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .ram_we(ram_we), .ram_waddr(ram_waddr),
        .ram_raddr(ram_raddr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(0)) dut_nw (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(n_gnt0), .gnt1(n_gnt1), .rvalid0(n_rvalid0), .rvalid1(n_rvalid1),
        .rdata(n_rdata), .ram_we(n_ram_we), .ram_waddr(n_ram_waddr),
        .ram_raddr(n_ram_raddr), .ram_din(n_ram_din), .ram_dout(n_ram_dout)
    );

    // Synchronous RAM, 1-cycle registered read, read-old-data on collision.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_waddr] <= ram_din;
        ram_dout <= mem[ram_raddr];
    end

    // Reference model state
    typedef struct {
        int            due;
        bit            port;
        logic [DW-1:0] data;
    } rd_t;

    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    rd_t           rdq[$];
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;
    int            mwait = 0;
    int            nwait = 0;
    bit            exp_we = 0;
    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_din = '0;

    bit            last_g0, last_g1;
    bit            last_dut_g0, last_dut_g1, last_nw_g1;
    bit            last_rv0, last_rv1, last_ram_we;

    typedef struct {
        bit            r0, r1, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        bit            eg0, eg1;
    } tv_t;
    tv_t tbl [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " gnt0"}, gnt0, 0);
        chk({tag, " gnt1"}, gnt1, 0);
        chk({tag, " rvalid0"}, rvalid0, 0);
        chk({tag, " rvalid1"}, rvalid1, 0);
        chk({tag, " ram_we"}, ram_we, 0);
        chk({tag, " ram_waddr"}, ram_waddr, 0);
        chk({tag, " ram_raddr"}, ram_raddr, 0);
        chk({tag, " ram_din"}, ram_din, 0);
        chk({tag, " nw gnt0"}, n_gnt0, 0);
        chk({tag, " nw gnt1"}, n_gnt1, 0);
        chk({tag, " nw rvalid"}, {n_rvalid1, n_rvalid0}, 0);
        chk({tag, " nw ram"}, {n_ram_we, n_ram_waddr, n_ram_raddr, n_ram_din}, 0);
        chk({tag, " nw rdata"}, n_rdata, 0);
    endtask

    // One clock cycle: drive, check at the falling edge, advance the model.
    task automatic cycle(input bit r0, input bit r1, input bit w0, input bit w1,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [DW-1:0] d0, input logic [DW-1:0] d1);
        bit            aged, g0, g1, ng0, ng1, wr;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        rd_t           e;
        req0 = r0; req1 = r1; we0 = w0; we1 = w1;
        addr0 = a0; addr1 = a1; wdata0 = d0; wdata1 = d1;
        @(negedge clk);
        // Port 1 owns the cycle once it has been refused 4 times in a row.
        aged = (mwait >= 4);
        g1   = r1 && (aged || !r0);
        g0   = r0 && !aged;
        ng1  = r1 && !r0;
        ng0  = r0;
        chk("gnt0", gnt0, g0);
        chk("gnt1", gnt1, g1);
        chk("nw gnt0", n_gnt0, ng0);
        chk("nw gnt1", n_gnt1, ng1);
        if (rdq.size() > 0 && rdq[0].due == cyc) begin
            e = rdq.pop_front();
            chk("rvalid0", rvalid0, !e.port);
            chk("rvalid1", rvalid1, e.port);
            chk("rdata", rdata, e.data);
        end else begin
            chk("rvalid0 idle", rvalid0, 0);
            chk("rvalid1 idle", rvalid1, 0);
        end
        chk("ram_we", ram_we, exp_we);
        chk("ram_waddr", ram_waddr, exp_addr);
        chk("ram_raddr", ram_raddr, exp_addr);
        chk("ram_din", ram_din, exp_din);

        last_g0 = g0; last_g1 = g1;
        last_dut_g0 = gnt0; last_dut_g1 = gnt1; last_nw_g1 = n_gnt1;
        last_rv0 = rvalid0; last_rv1 = rvalid1; last_ram_we = ram_we;

        if (g0 || g1) begin
            wr = g1 ? w1 : w0;
            a  = g1 ? a1 : a0;
            d  = g1 ? d1 : d0;
            exp_we = wr; exp_addr = a; exp_din = d;
            if (wr) model_mem[a] = d;
            else rdq.push_back('{cyc + 2, g1, model_mem[a]});
        end else begin
            exp_we = 0;
        end
        mwait = (!r1 || g1) ? 0 : ((mwait < 255) ? mwait + 1 : 255);
        nwait = (!r1 || ng1) ? 0 : ((nwait < 255) ? nwait + 1 : 255);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(0, 0, 0, 0, '0, '0, '0, '0);
    endtask

    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        #2;
        chk_zero(tag);
        repeat (2) begin
            @(posedge clk);
            cyc++;
        end
        #1;
        chk_zero(tag);
        rst = 1'b0;
        rdq.delete();
        mwait = 0; nwait = 0;
        exp_we = 0; exp_addr = '0; exp_din = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        bit            p0, p1, rw0, rw1;
        logic [AW-1:0] ra0, ra1;
        logic [DW-1:0] rd0, rd1;

        tbl[0]  = '{0, 0, 0, 9'h000, 8'h00, 0, 0};
        tbl[1]  = '{1, 0, 1, 9'h003, 8'h11, 1, 0};
        tbl[2]  = '{0, 1, 0, 9'h000, 8'h00, 0, 1};
        tbl[3]  = '{1, 1, 0, 9'h003, 8'h00, 1, 0};
        tbl[4]  = '{1, 1, 0, 9'h004, 8'h00, 1, 0};
        tbl[5]  = '{1, 1, 0, 9'h005, 8'h00, 1, 0};
        tbl[6]  = '{1, 1, 0, 9'h006, 8'h00, 1, 0};
        tbl[7]  = '{1, 1, 0, 9'h008, 8'h00, 0, 1};
        tbl[8]  = '{1, 1, 0, 9'h008, 8'h00, 1, 0};
        tbl[9]  = '{0, 1, 0, 9'h000, 8'h00, 0, 1};
        tbl[10] = '{1, 1, 1, 9'h009, 8'h22, 1, 0};
        tbl[11] = '{1, 1, 0, 9'h009, 8'h00, 1, 0};
        tbl[12] = '{0, 1, 0, 9'h000, 8'h00, 0, 1};
        tbl[13] = '{0, 0, 0, 9'h000, 8'h00, 0, 0};

        rst = 1'b1;
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        pl_en = 1'b0; pl_addr = '0; pl_data = '0;
        #3;
        chk_zero("reset_init");

        @(posedge clk);
        #1;
        for (int i = 0; i < 16; i++) begin
            pl_en   = 1'b1;
            pl_addr = AW'(i);
            pl_data = (i == 5) ? 8'hA5 : 8'($urandom);
            model_mem[i] = pl_data;
            @(posedge clk);
            #1;
            cyc++;
        end
        pl_en = 1'b0;
        reset_pulse("reset_hold");

        // Grant table from a freshly reset aging counter.
        for (int i = 0; i < 14; i++) begin
            cycle(tbl[i].r0, tbl[i].r1, tbl[i].w0, 0, tbl[i].a0, 9'h007, tbl[i].d0, 8'h00);
            chk($sformatf("tbl%0d gnt0", i), last_dut_g0, tbl[i].eg0);
            chk($sformatf("tbl%0d gnt1", i), last_dut_g1, tbl[i].eg1);
        end
        idle(3);

        // Single read of a preloaded word.
        cycle(1, 0, 0, 0, 9'h005, '0, '0, '0);
        chk("single gnt0", last_dut_g0, 1);
        idle(1);
        chk("single early rvalid0", last_rv0, 0);
        idle(1);
        chk("single rvalid0", last_rv0, 1);
        chk("single rvalid1", last_rv1, 0);
        idle(1);

        // Port 1 write then read of the top address.
        cycle(0, 1, 0, 1, '0, 9'h1FF, '0, 8'h3C);
        cycle(0, 1, 0, 0, '0, 9'h1FF, '0, '0);
        chk("wr ram_we", last_ram_we, 1);
        idle(1);
        chk("wr ram_we drop", last_ram_we, 0);
        idle(1);
        chk("wr_rd rvalid1", last_rv1, 1);
        idle(1);

        // Back-to-back mixed-port reads.
        cycle(1, 0, 0, 0, 9'h001, '0, '0, '0);
        cycle(0, 1, 0, 0, '0, 9'h002, '0, '0);
        cycle(1, 0, 0, 0, 9'h003, '0, '0, '0);
        chk("b2b rvalid0 a", last_rv0, 1);
        idle(1);
        chk("b2b rvalid1", last_rv1, 1);
        idle(1);
        chk("b2b rvalid0 b", last_rv0, 1);
        idle(2);

        // Reset one cycle after a read transfer.
        cycle(1, 0, 0, 0, 9'h005, '0, '0, '0);
        reset_pulse("reset_mid_read");
        cycle(1, 0, 0, 0, 9'h005, '0, '0, '0);
        chk("post_reset gnt0", last_dut_g0, 1);
        idle(1);
        idle(1);
        chk("post_reset rvalid0", last_rv0, 1);
        idle(4);

        // Both ports held: 4:1 pattern on the aged instance, starvation without aging.
        for (int i = 0; i < 300; i++) begin
            cycle(1, 1, 0, 0, 9'h004, 9'h006, '0, '0);
            chk("contention gnt1", last_dut_g1, (i % 5) == 4);
            chk("nowait gnt1", last_nw_g1, 0);
        end
        chk("nowait wait_cnt sat", dut_nw.wait_cnt_q, 8'hFF);
        idle(3);

        // Randomized traffic that honours hold-until-granted.
        p0 = 0; p1 = 0;
        rw0 = 0; rw1 = 0; ra0 = '0; ra1 = '0; rd0 = '0; rd1 = '0;
        for (int i = 0; i < 400; i++) begin
            if (!p0 && $urandom_range(0, 99) < 60) begin
                p0 = 1; rw0 = 1'($urandom); ra0 = AW'($urandom_range(0, 15)); rd0 = DW'($urandom);
            end
            if (!p1 && $urandom_range(0, 99) < 50) begin
                p1 = 1; rw1 = 1'($urandom); ra1 = AW'($urandom_range(0, 15)); rd1 = DW'($urandom);
            end
            cycle(p0, p1, rw0, rw1, ra0, ra1, rd0, rd1);
            if (last_g0) p0 = 0;
            if (last_g1) p1 = 0;
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
